// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational 32-bit ALU between
// two issue slots, with a single registered result stage (result, tag, source slot)
// toward writeback/bypass. The ALU itself lives outside this block.
module alu_share_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_cont,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_cont,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_cont,
    input  logic [31:0]      alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

    // Result stage and round-robin pointer (ptr_q names the slot favoured on a tie).
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_src_q, out_src_d;
    logic             ptr_q, ptr_d;

    logic stage_free;
    logic can_grant;
    logic grant0;
    logic grant1;

    // The stage can take a new result when empty or being drained this cycle;
    // flush and reset suppress any grant.
    assign stage_free = !out_valid_q || out_ready;
    assign can_grant  = stage_free && !flush && !reset;

    // A lone valid slot always wins; on a tie the pointer decides.
    assign grant0 = can_grant && req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = can_grant && req1_valid && (!req0_valid ||  ptr_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the granted slot's operands to the shared ALU; idle ALU sees zeros.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        alu_a    = '0;
        alu_b    = '0;
        alu_cont = '0;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_cont = req0_cont;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_cont = req1_cont;
        end
    end

    // Next state of the result stage and pointer: flush drops, grant loads, consume empties.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_src_d    = out_src_q;
        ptr_d        = ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (grant0 || grant1) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_tag_d    = grant1 ? req1_tag : req0_tag;
            out_src_d    = grant1;
            ptr_d        = grant0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_src_q    <= 1'b0;
            ptr_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_src_q    <= out_src_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_src    = out_src_q;

endmodule
